// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: widths, the
// {dest, data} result record, the grant encoding and a one-hot helper.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2
  } grant_e;

  // One-hot of a register address; r0 is never reported as pending.
  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] dest);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    if (dest != '0) vec[dest] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / MDU (master side) and the arbiter
// (slave side), including the register-file write port and hazard mask.
//
// Handshakes:
//   WB : a request (wbValid, wbDest != 0) is written in any cycle where
//        wbStall = 0; while wbStall = 1 the WB stage holds wbDest/wbData.
//   MDU: a result transfers on a cycle with mduValid && mduReady; a
//        transfer to mduDest = 0 completes but is dropped.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic                  wbValid;
  logic [REG_ADDR_W-1:0] wbDest;
  logic [DATA_W-1:0]     wbData;
  logic                  wbStall;
  logic                  mduValid;
  logic [REG_ADDR_W-1:0] mduDest;
  logic [DATA_W-1:0]     mduData;
  logic                  mduReady;
  logic                  regWriteEnable;
  logic [REG_ADDR_W-1:0] regWriteAddr;
  logic [DATA_W-1:0]     regWriteData;
  logic [NUM_REGS-1:0]   pendingMask;

  modport master (
    output wbValid, wbDest, wbData, mduValid, mduDest, mduData,
    input  wbStall, mduReady, regWriteEnable, regWriteAddr, regWriteData, pendingMask
  );

  modport slave (
    input  wbValid, wbDest, wbData, mduValid, mduDest, mduData,
    output wbStall, mduReady, regWriteEnable, regWriteAddr, regWriteData, pendingMask
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Two-entry FIFO holding MDU results that are waiting for the write port.
// Every slot is visible so the arbiter can match WB destinations against
// queued writes and build the pending mask.
module wb_result_fifo
  import wb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wb_req_t           pushEntry,
  input  logic              pop,
  output logic [1:0]        count,
  output wb_req_t           headEntry,
  output wb_req_t [1:0]     slotEntry,
  output logic [1:0]        slotValid
);

  wb_req_t [1:0] mem;
  logic          head;
  logic          tail;
  logic          pushOk;
  logic          popOk;

  // Never overfill or underflow, whatever the caller asks for.
  assign pushOk = push && (count != 2'd2);
  assign popOk  = pop  && (count != 2'd0);

  // Storage, pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pushOk) begin
        mem[tail] <= pushEntry;
        tail      <= ~tail;
      end
      if (popOk) head <= ~head;
      case ({pushOk, popOk})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when the FIFO is full, or it is the head of a single entry.
  always_comb begin
    slotValid = '0;
    for (int i = 0; i < 2; i++) begin
      slotValid[i] = (count == 2'd2) || ((count == 2'd1) && (head == 1'(i)));
    end
  end

  assign headEntry = mem[head];
  assign slotEntry = mem;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage and the MDU. WB wins by default; queued MDU results go first when WB
// is idle, when the queue is full, when the head has waited STARVE_LIMIT
// cycles, or when WB targets a register that still has an older MDU write
// queued (so the younger WB value lands last).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
);

  localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [1:0]            count;
  wb_req_t               headEntry;
  wb_req_t [1:0]         slotEntry;
  logic [1:0]            slotValid;
  logic                  wbReq;
  logic                  mduReq;
  logic                  destHit;
  logic                  pushEn;
  grant_e                grant;
  logic [STARVE_W-1:0]   starveCnt;
  logic                  outEnable;
  logic [REG_ADDR_W-1:0] outAddr;
  logic [DATA_W-1:0]     outData;
  logic                  outIsMdu;

  assign wbReq  = bus.wbValid && (bus.wbDest != '0);
  assign mduReq = (count != 2'd0);
  assign pushEn = bus.mduValid && bus.mduReady && (bus.mduDest != '0);

  wb_result_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pushEn),
    .pushEntry ('{dest: bus.mduDest, data: bus.mduData}),
    .pop       (grant == GNT_MDU),
    .count     (count),
    .headEntry (headEntry),
    .slotEntry (slotEntry),
    .slotValid (slotValid)
  );

  // Does the WB destination collide with any queued (older) MDU write?
  always_comb begin
    destHit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (slotValid[i] && (slotEntry[i].dest == bus.wbDest)) destHit = 1'b1;
    end
  end

  // Same-cycle grant decision for the write port.
  always_comb begin
    grant = GNT_NONE;
    if (mduReq && (!wbReq || (count == 2'd2) || (starveCnt == STARVE_MAX) || (wbReq && destHit))) begin
      grant = GNT_MDU;
    end else if (wbReq) begin
      grant = GNT_WB;
    end
  end

  assign bus.wbStall  = wbReq && (grant == GNT_MDU);
  assign bus.mduReady = (count != 2'd2);

  // Count cycles the head has been passed over; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if ((grant == GNT_MDU) || !mduReq) begin
      starveCnt <= '0;
    end else if (starveCnt != STARVE_MAX) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outEnable <= 1'b0;
      outAddr   <= '0;
      outData   <= '0;
      outIsMdu  <= 1'b0;
    end else begin
      case (grant)
        GNT_MDU: begin
          outEnable <= 1'b1;
          outAddr   <= headEntry.dest;
          outData   <= headEntry.data;
          outIsMdu  <= 1'b1;
        end
        GNT_WB: begin
          outEnable <= 1'b1;
          outAddr   <= bus.wbDest;
          outData   <= bus.wbData;
          outIsMdu  <= 1'b0;
        end
        default: begin
          outEnable <= 1'b0;
        end
      endcase
    end
  end

  // Registers with an MDU write still in flight (queued or being written).
  always_comb begin
    bus.pendingMask = '0;
    for (int i = 0; i < 2; i++) begin
      if (slotValid[i]) bus.pendingMask = bus.pendingMask | dest_onehot(slotEntry[i].dest);
    end
    if (outEnable && outIsMdu) bus.pendingMask = bus.pendingMask | dest_onehot(outAddr);
    bus.pendingMask[0] = 1'b0;
  end

  assign bus.regWriteEnable = outEnable;
  assign bus.regWriteAddr   = outAddr;
  assign bus.regWriteData   = outData;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed cycle table, a mid-drain reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int LIMIT = 4;
  localparam int RAND_CYCLES = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic        wbV;
    logic [4:0]  wbD;
    logic [31:0] wbDt;
    logic        mV;
    logic [4:0]  mD;
    logic [31:0] mDt;
    logic        eStall;
    logic        eReady;
    logic        eWe;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    logic [31:0] eMask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic wbV, input logic [4:0] wbD, input logic [31:0] wbDt,
                             input logic mV, input logic [4:0] mD, input logic [31:0] mDt,
                             input logic eStall, input logic eReady, input logic eWe,
                             input logic [4:0] eAddr, input logic [31:0] eData, input logic [31:0] eMask);
    vec_t r;
    r.wbV = wbV; r.wbD = wbD; r.wbDt = wbDt;
    r.mV = mV; r.mD = mD; r.mDt = mDt;
    r.eStall = eStall; r.eReady = eReady; r.eWe = eWe;
    r.eAddr = eAddr; r.eData = eData; r.eMask = eMask;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wbV, input logic [4:0] wbD, input logic [31:0] wbDt,
                       input logic mV, input logic [4:0] mD, input logic [31:0] mDt);
    bus.wbValid  = wbV;
    bus.wbDest   = wbD;
    bus.wbData   = wbDt;
    bus.mduValid = mV;
    bus.mduDest  = mD;
    bus.mduData  = mDt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic eStall, input logic eReady, input logic eWe,
                           input logic [4:0] eAddr, input logic [31:0] eData, input logic [31:0] eMask);
    check({tag, ".stall"}, 32'(bus.wbStall), 32'(eStall));
    check({tag, ".ready"}, 32'(bus.mduReady), 32'(eReady));
    check({tag, ".we"},    32'(bus.regWriteEnable), 32'(eWe));
    check({tag, ".addr"},  32'(bus.regWriteAddr), 32'(eAddr));
    check({tag, ".data"},  bus.regWriteData, eData);
    check({tag, ".mask"},  bus.pendingMask, eMask);
  endtask

  // ---------------- reference model ----------------
  // Queue of waiting MDU results, starvation age of the head, and the
  // contents of the write port register.
  wb_req_t     mq[$];
  int          mStarve;
  logic        mEn;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic        mIsMdu;
  logic        mGnt;
  logic        eStall;
  logic        eReady;
  logic [31:0] eMask;

  task automatic model_reset();
    mq.delete();
    mStarve = 0;
    mEn = 1'b0; mAddr = '0; mData = '0; mIsMdu = 1'b0;
  endtask

  // Decide this cycle from the current inputs (called between edges).
  task automatic model_eval();
    logic wbReq;
    logic hit;
    wbReq = bus.wbValid && (bus.wbDest != 0);
    hit = 1'b0;
    foreach (mq[k]) if (mq[k].dest == bus.wbDest) hit = 1'b1;
    mGnt = (mq.size() > 0) &&
           (!wbReq || mq.size() == 2 || mStarve == LIMIT || (wbReq && hit));
    eStall = wbReq && mGnt;
    eReady = (mq.size() < 2);
    eMask = '0;
    foreach (mq[k]) eMask[mq[k].dest] = 1'b1;
    if (mEn && mIsMdu) eMask[mAddr] = 1'b1;
    eMask[0] = 1'b0;
  endtask

  // Apply the clock edge to the model.
  task automatic model_step();
    wb_req_t h;
    int n;
    logic wbReq;
    n = mq.size();
    wbReq = bus.wbValid && (bus.wbDest != 0);
    if (mGnt) begin
      h = mq.pop_front();
      mEn = 1'b1; mAddr = h.dest; mData = h.data; mIsMdu = 1'b1;
    end else if (wbReq) begin
      mEn = 1'b1; mAddr = bus.wbDest; mData = bus.wbData; mIsMdu = 1'b0;
    end else begin
      mEn = 1'b0;
    end
    if (mGnt || n == 0) mStarve = 0;
    else if (mStarve < LIMIT) mStarve++;
    if (bus.mduValid && n < 2 && bus.mduDest != 0) begin
      h.dest = bus.mduDest;
      h.data = bus.mduData;
      mq.push_back(h);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic holdWb;
    logic holdMdu;

    // Row format: wbV wbD wbData | mV mD mData || stall ready we addr data mask
    vecs.push_back(v(0,  0, 32'h0,        1,  5, 32'h12345678, 0, 1, 0,  0, 32'h0,        32'h0));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 0,  0, 32'h0,        32'h20));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 1,  5, 32'h12345678, 32'h20));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 0,  5, 32'h12345678, 32'h0));
    // WB to r3 every cycle; MDU r7 is forced through after 4 denied cycles
    vecs.push_back(v(1,  3, 32'hA0,       1,  7, 32'h77,       0, 1, 0,  5, 32'h12345678, 32'h0));
    vecs.push_back(v(1,  3, 32'hA1,       0,  0, 32'h0,        0, 1, 1,  3, 32'hA0,       32'h80));
    vecs.push_back(v(1,  3, 32'hA2,       0,  0, 32'h0,        0, 1, 1,  3, 32'hA1,       32'h80));
    vecs.push_back(v(1,  3, 32'hA3,       0,  0, 32'h0,        0, 1, 1,  3, 32'hA2,       32'h80));
    vecs.push_back(v(1,  3, 32'hA4,       0,  0, 32'h0,        0, 1, 1,  3, 32'hA3,       32'h80));
    vecs.push_back(v(1,  3, 32'hA5,       0,  0, 32'h0,        1, 1, 1,  3, 32'hA4,       32'h80));
    vecs.push_back(v(1,  3, 32'hA5,       0,  0, 32'h0,        0, 1, 1,  7, 32'h77,       32'h80));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 1,  3, 32'hA5,       32'h0));
    // WAW: queued r9 goes ahead of WB r9
    vecs.push_back(v(0,  0, 32'h0,        1,  9, 32'h99,       0, 1, 0,  3, 32'hA5,       32'h0));
    vecs.push_back(v(1,  9, 32'hB9,       0,  0, 32'h0,        1, 1, 0,  3, 32'hA5,       32'h200));
    vecs.push_back(v(1,  9, 32'hB9,       0,  0, 32'h0,        0, 1, 1,  9, 32'h99,       32'h200));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 1,  9, 32'hB9,       32'h0));
    // r0 destinations on both sides are dropped
    vecs.push_back(v(1,  0, 32'hDEAD,     1,  0, 32'hBEEF,     0, 1, 0,  9, 32'hB9,       32'h0));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 0,  9, 32'hB9,       32'h0));
    // three back-to-back MDU results while WB is busy
    vecs.push_back(v(1,  3, 32'hC0,       1, 10, 32'h10A,      0, 1, 0,  9, 32'hB9,       32'h0));
    vecs.push_back(v(1,  3, 32'hC1,       1, 11, 32'h10B,      0, 1, 1,  3, 32'hC0,       32'h400));
    vecs.push_back(v(1,  3, 32'hC2,       1, 12, 32'h10C,      1, 0, 1,  3, 32'hC1,       32'hC00));
    vecs.push_back(v(1,  3, 32'hC2,       1, 12, 32'h10C,      0, 1, 1, 10, 32'h10A,      32'hC00));
    vecs.push_back(v(1,  3, 32'hC3,       0,  0, 32'h0,        1, 0, 1,  3, 32'hC2,       32'h1800));
    vecs.push_back(v(1,  3, 32'hC3,       0,  0, 32'h0,        0, 1, 1, 11, 32'h10B,      32'h1800));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 1,  3, 32'hC3,       32'h1000));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 1, 12, 32'h10C,      32'h1000));
    vecs.push_back(v(0,  0, 32'h0,        0,  0, 32'h0,        0, 1, 0, 12, 32'h10C,      32'h0));
    // build two queued entries with the head aged 3 cycles
    vecs.push_back(v(1,  3, 32'hD0,       1, 20, 32'h2000,     0, 1, 0, 12, 32'h10C,      32'h0));
    vecs.push_back(v(1,  3, 32'hD1,       0,  0, 32'h0,        0, 1, 1,  3, 32'hD0,       32'h100000));
    vecs.push_back(v(1,  3, 32'hD2,       0,  0, 32'h0,        0, 1, 1,  3, 32'hD1,       32'h100000));
    vecs.push_back(v(1,  3, 32'hD3,       1, 21, 32'h2100,     0, 1, 1,  3, 32'hD2,       32'h100000));

    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].wbV, vecs[i].wbD, vecs[i].wbDt, vecs[i].mV, vecs[i].mD, vecs[i].mDt);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].eStall, vecs[i].eReady, vecs[i].eWe,
                vecs[i].eAddr, vecs[i].eData, vecs[i].eMask);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with a full queue and an aged head.
    drive(1, 3, 32'hD4, 0, 0, 0);
    @(negedge clk);
    check_all("prerst", 1'b1, 1'b0, 1'b1, 5'd3, 32'hD3, 32'h300000);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("midrst", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_all($sformatf("postrst%0d", c), 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    holdWb = 1'b0;
    holdMdu = 1'b0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      if (!holdWb) begin
        bus.wbValid = ($urandom_range(0, 99) < 60);
        bus.wbDest  = 5'($urandom_range(0, 7));
        bus.wbData  = $urandom();
      end
      if (!holdMdu) begin
        bus.mduValid = ($urandom_range(0, 99) < 40);
        bus.mduDest  = 5'($urandom_range(0, 7));
        bus.mduData  = $urandom();
      end
      @(negedge clk);
      model_eval();
      check_all($sformatf("rnd%0d", c), eStall, eReady, mEn, mAddr, mData, eMask);
      holdWb  = eStall;
      holdMdu = bus.mduValid && !eReady;
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). WB results take priority; MDU results queue in a 2-entry buffer and drain on idle WB slots, or by stalling WB when the buffer is full, when a queued entry has starved, or when ordering requires it. Sits between the WB-stage result mux/MDU and the register file, and publishes a pending-destination mask to the hazard unit.

## Interface
- STARVE_LIMIT, 4: maximum consecutive denied cycles for a queued MDU result before it is forced through (≥1)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wbValid  in  1  WB stage requests a register write this cycle
- wbDest  in  5  WB destination register
- wbData  in  32  WB write data (output of the WB mem/ALU select)
- wbStall  out  1  hold WB stage and upstream this cycle
- mduValid  in  1  MDU result valid
- mduDest  in  5  MDU destination register
- mduData  in  32  MDU result
- mduReady  out  1  buffer can accept; transfer when mduValid && mduReady
- regWriteEnable  out  1  register-file write enable (registered)
- regWriteAddr  out  5  register-file write address (registered)
- regWriteData  out  32  register-file write data (registered)
- pendingMask  out  32  bit r set while an MDU write to r is queued or in the output register

## Operation
- Buffer: 2 entries {dest, data}, 1-bit head/tail, count 0..2. mduReady = (count != 2).
- Push on mduValid && mduReady && mduDest != 0. mduDest == 0: handshake completes, nothing queued.
- wbReq = wbValid && wbDest != 0. mduReq = count != 0.
- Grant MDU when mduReq && (!wbReq || count == 2 || starveCnt == STARVE_LIMIT || wbDest matches any valid entry dest). Otherwise grant WB if wbReq.
- WAW rule: a queued MDU result is older than any WB write to the same register, so it writes first.
- wbStall = wbReq && MDU granted. Never asserted when wbReq = 0.
- MDU grant pops the head. Push and pop in the same cycle are both honoured; count is unchanged.
- starveCnt, 0..STARVE_LIMIT, saturating: clears on MDU grant or when the buffer is empty. Increments when mduReq is true and MDU is not granted.
- Output register loads the granted {dest, data} with regWriteEnable = 1. With no grant, regWriteEnable = 0; addr and data hold.
- outIsMdu flag records that the output register holds an MDU write.
- pendingMask = OR of one-hot(dest) over valid buffer entries, plus one-hot(regWriteAddr) when regWriteEnable && outIsMdu. Bit 0 is always 0.
- Reset (asynchronous, any time, including mid-drain): buffer emptied, count = 0, starveCnt = 0, regWriteEnable = 0, regWriteAddr = 0, regWriteData = 0, outIsMdu = 0. Resulting outputs: pendingMask = 0, mduReady = 1, wbStall = 0. Queued results are discarded.

## Timing
- Grant and wbStall are combinational in the same cycle as the request. A stalled WB presents identical wbDest and wbData next cycle.
- Write-port latency: 1 cycle from grant to regWriteEnable.
- MDU latency: empty buffer, idle WB → push at edge N, grant in cycle N+1, regWriteEnable in cycle N+2.
- Starvation bound: a head entry waits at most STARVE_LIMIT denied cycles.
- Full buffer: mduReady = 0 in that cycle. A pop makes mduReady = 1 from the next cycle.
- pendingMask bits set the cycle after push and clear the cycle after the write is presented.

## Structure
- Shared package wb_arb_pkg: REG_ADDR_W = 5, DATA_W = 32, struct wb_req_t {dest, data}, grant encoding GNT_NONE / GNT_WB / GNT_MDU.
- Sub-module wb_result_fifo: 2-entry buffer with push, pop, count, and entry-dest visibility for the match and mask logic.
- Top level holds the grant logic, starvation counter, output register and mask.

## Test plan
- Idle WB; MDU pushes dest 5, data 0x12345678 → regWriteEnable = 1, addr 5, data 0x12345678 two cycles after push; pendingMask bit 5 high for those cycles, then 0.
- WB writes every cycle to dest 3; one MDU result to dest 7 queued, STARVE_LIMIT = 4 → WB is granted 4 cycles, then wbStall = 1 for one cycle, then reg7 is written, then WB resumes.
- MDU result to dest 9 queued; WB requests dest 9 → wbStall = 1; MDU value is written first, WB value next cycle; final write address 9 carries the WB data.
- MDU pushes three back-to-back results while WB is busy → mduReady = 0 after two; a full buffer forces MDU grants with wbStall; all three written in order.
- wbValid with wbDest = 0, and an MDU push with mduDest = 0 → no write, no stall, pendingMask = 0.
- rst_n asserted with two queued entries and starveCnt = 3 → all outputs go to reset values immediately; no write of the discarded data after release.
